// File: rtl/imem_fetch.sv
// Instruction-fetch initiator: holds the PC, issues single-word reads to the
// instruction memory, and hands captured words to decode over valid/ready.
module imem_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] ADDR_MASK = 32'hFFFF_FFFC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_data,
  input  logic        mem_oe,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] fetch_count
);

  // Word alignment is enforced even if ADDR_MASK leaves the low bits open.
  localparam logic [31:0] LOAD_MASK = ADDR_MASK & 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic        discard, discard_n;
  logic        inst_valid_n;
  logic [31:0] inst_n, inst_pc_n, fetch_count_n;
  logic [31:0] redirect_target;

  assign redirect_target = redirect_pc & LOAD_MASK;
  assign mem_re          = (state == S_REQ);
  assign mem_addr        = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pc          <= RESET_PC & LOAD_MASK;
      discard     <= 1'b0;
      inst_valid  <= 1'b0;
      inst        <= '0;
      inst_pc     <= '0;
      fetch_count <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      discard     <= discard_n;
      inst_valid  <= inst_valid_n;
      inst        <= inst_n;
      inst_pc     <= inst_pc_n;
      fetch_count <= fetch_count_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    discard_n     = discard;
    inst_valid_n  = inst_valid;
    inst_n        = inst;
    inst_pc_n     = inst_pc;
    fetch_count_n = fetch_count;

    case (state)
      S_IDLE: begin
        if (redirect_valid) begin
          pc_n = redirect_target;
        end else if (run) begin
          state_n = S_REQ;
        end
      end

      S_REQ: begin
        // The request already went out this cycle; its response becomes stale.
        if (redirect_valid) begin
          pc_n      = redirect_target;
          discard_n = 1'b1;
        end
        state_n = S_WAIT;
      end

      S_WAIT: begin
        if (redirect_valid) begin
          pc_n = redirect_target;
          if (mem_oe) begin
            // The arriving response is the only outstanding one; drop it and refetch.
            discard_n = 1'b0;
            state_n   = S_REQ;
          end else begin
            discard_n = 1'b1;
          end
        end else if (mem_oe) begin
          if (discard) begin
            discard_n = 1'b0;
            state_n   = S_REQ;
          end else begin
            inst_n       = mem_data;
            inst_pc_n    = pc;
            inst_valid_n = 1'b1;
            pc_n         = (pc + 32'd4) & LOAD_MASK;
            state_n      = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redirect_valid) begin
          pc_n         = redirect_target;
          inst_valid_n = 1'b0;
          state_n      = run ? S_REQ : S_IDLE;
        end else if (inst_valid && inst_ready) begin
          inst_valid_n  = 1'b0;
          fetch_count_n = fetch_count + 32'd1;
          state_n       = run ? S_REQ : S_IDLE;
        end
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_fetch.sv
// Scoreboard bench for imem_fetch: a delay-programmable responder model feeds
// the fetcher, and every delivered instruction is matched against a queue.
module tb_imem_fetch;

  logic        clk = 1'b0;
  logic        rst, run, redirect_valid, inst_ready;
  logic [31:0] redirect_pc;
  logic [31:0] mem_addr, mem_data, inst, inst_pc, fetch_count;
  logic        mem_re, mem_oe, inst_valid;

  logic        run2, mem_re2, inst_valid2;
  logic [31:0] mem_addr2, inst2, inst_pc2, fetch_count2;

  logic          zero_mode;
  int unsigned   delay;
  logic [31:0]   mem [0:255];
  logic          pend;
  int unsigned   cnt;
  logic [31:0]   rdata;

  typedef struct {
    logic [31:0] w;
    logic [31:0] a;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_fetch dut (
    .clk(clk), .rst(rst), .run(run),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_data(mem_data), .mem_oe(mem_oe),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .inst_pc(inst_pc), .fetch_count(fetch_count)
  );

  imem_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .run(run2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .mem_addr(mem_addr2), .mem_re(mem_re2), .mem_data(32'hABCD_0013), .mem_oe(1'b1),
    .inst_valid(inst_valid2), .inst_ready(1'b1), .inst(inst2),
    .inst_pc(inst_pc2), .fetch_count(fetch_count2)
  );

  // Responder: zero-delay mode holds oe high; otherwise oe pulses 'delay' cycles after the request.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend  <= 1'b0;
      cnt   <= 0;
      rdata <= '0;
    end else begin
      if (pend) begin
        if (cnt == 1) pend <= 1'b0;
        else cnt <= cnt - 1;
      end
      if (mem_re && !zero_mode) begin
        pend  <= 1'b1;
        cnt   <= delay;
        rdata <= mem[mem_addr[9:2]];
      end
    end
  end

  assign mem_oe   = zero_mode ? 1'b1 : (pend && cnt == 1);
  assign mem_data = zero_mode ? mem[mem_addr[9:2]] : rdata;

  always @(negedge clk) begin
    if (!rst && inst_valid && inst_ready && !redirect_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL deliver_unexpected inst=%h pc=%h required=none", inst, inst_pc);
      end else begin
        e = exp_q.pop_front();
        if (inst !== e.w || inst_pc !== e.a) begin
          bad++;
          $display("FAIL deliver got inst=%h pc=%h required inst=%h pc=%h", inst, inst_pc, e.w, e.a);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    total++;
    if (mem_re !== 1'b0 || mem_addr !== 32'h0 || inst_valid !== 1'b0 ||
        inst !== 32'h0 || inst_pc !== 32'h0 || fetch_count !== 32'h0) begin
      bad++;
      $display("FAIL reset_values got re=%b addr=%h v=%b inst=%h pc=%h cnt=%h required all zero",
               mem_re, mem_addr, inst_valid, inst, inst_pc, fetch_count);
    end
    total++;
    if (mem_addr2 !== 32'hFFFF_FFFC || mem_re2 !== 1'b0) begin
      bad++;
      $display("FAIL reset_pc_param got addr=%h re=%b required addr=fffffffc re=0", mem_addr2, mem_re2);
    end
  endtask

  task automatic test_zero_delay();
    int unsigned ec[3];
    logic [31:0] ea[3];
    int unsigned nreq = 0;
    ec = '{1, 4, 7};
    ea = '{32'h0, 32'h4, 32'h8};
    exp_q.push_back('{32'h0000_0013, 32'h0});
    exp_q.push_back('{32'h0010_0093, 32'h4});
    exp_q.push_back('{32'h0020_0113, 32'h8});
    for (int i = 0; i < 12; i++) begin
      step();
      if (i == 0) begin
        zero_mode = 1'b1; inst_ready = 1'b1; run = 1'b1; rst = 1'b0;
      end
      if (i == 8) run = 1'b0;
      @(negedge clk);
      if (mem_re) begin
        total++;
        if (nreq >= 3 || i != ec[nreq] || mem_addr !== ea[nreq]) begin
          bad++;
          $display("FAIL zd_req got cycle=%0d addr=%h (req#%0d)", i, mem_addr, nreq);
        end
        nreq++;
      end
    end
    total++;
    if (nreq != 3) begin bad++; $display("FAIL zd_req_count got=%0d required=3", nreq); end
    total++;
    if (fetch_count !== 32'd3) begin bad++; $display("FAIL zd_fetch_count got=%0d required=3", fetch_count); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL zd_drain got pending=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_stall();
    int unsigned nreq = 0;
    int first_valid = -1;
    exp_q.push_back('{32'h0030_0193, 32'hC});
    for (int i = 0; i < 15; i++) begin
      step();
      if (i == 0) begin
        zero_mode = 1'b0; delay = 3; inst_ready = 1'b0; run = 1'b1;
      end
      if (i == 1) run = 1'b0;
      inst_ready = (i >= 10);
      @(negedge clk);
      if (mem_re) nreq++;
      if (inst_valid) begin
        if (first_valid < 0) first_valid = i;
        total++;
        if (inst !== 32'h0030_0193 || inst_pc !== 32'hC) begin
          bad++;
          $display("FAIL stall_stable got inst=%h pc=%h required inst=00300193 pc=0000000c", inst, inst_pc);
        end
      end
      if (i == 10) begin
        total++;
        if (fetch_count !== 32'd3) begin bad++; $display("FAIL stall_no_early_count got=%0d required=3", fetch_count); end
      end
    end
    total++;
    if (first_valid != 5) begin bad++; $display("FAIL stall_valid_cycle got=%0d required=5", first_valid); end
    total++;
    if (nreq != 1) begin bad++; $display("FAIL stall_req_count got=%0d required=1", nreq); end
    total++;
    if (fetch_count !== 32'd4 || inst_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_transfer got cnt=%0d v=%b required cnt=4 v=0", fetch_count, inst_valid);
    end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL stall_drain got pending=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_redirect_wait();
    int unsigned ec[2];
    logic [31:0] ea[2];
    int unsigned nreq = 0;
    ec = '{2, 6};
    ea = '{32'h0, 32'h100};
    mem[0]  = 32'hDEAD_BEEF;
    mem[64] = 32'h0000_006F;
    exp_q.push_back('{32'h0000_006F, 32'h100});
    for (int i = 0; i < 14; i++) begin
      step();
      redirect_valid = 1'b0;
      if (i == 0) begin
        redirect_valid = 1'b1; redirect_pc = 32'h0; run = 1'b0; inst_ready = 1'b1; delay = 3;
      end
      if (i == 1) run = 1'b1;
      if (i == 3) begin redirect_valid = 1'b1; redirect_pc = 32'h100; end
      if (i == 6) run = 1'b0;
      @(negedge clk);
      if (mem_re) begin
        total++;
        if (nreq >= 2 || i != ec[nreq] || mem_addr !== ea[nreq]) begin
          bad++;
          $display("FAIL rw_req got cycle=%0d addr=%h (req#%0d)", i, mem_addr, nreq);
        end
        nreq++;
      end
      if (inst_valid) begin
        total++;
        if (inst === 32'hDEAD_BEEF) begin bad++; $display("FAIL rw_stale got inst=%h required not deadbeef", inst); end
      end
      if (i == 4) begin
        total++;
        if (mem_addr !== 32'h100) begin bad++; $display("FAIL rw_pc_update got=%h required=00000100", mem_addr); end
      end
    end
    total++;
    if (nreq != 2) begin bad++; $display("FAIL rw_req_count got=%0d required=2", nreq); end
    total++;
    if (fetch_count !== 32'd5) begin bad++; $display("FAIL rw_fetch_count got=%0d required=5", fetch_count); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rw_drain got pending=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_redirect_collide();
    int unsigned ec[3];
    logic [31:0] ea[3];
    int unsigned nreq = 0;
    ec = '{1, 4, 8};
    ea = '{32'h104, 32'h200, 32'h200};
    mem[65]  = 32'h1111_1111;
    mem[128] = 32'h2222_2222;
    exp_q.push_back('{32'h2222_2222, 32'h200});
    for (int i = 0; i < 14; i++) begin
      step();
      redirect_valid = 1'b0;
      if (i == 0) begin run = 1'b1; delay = 2; inst_ready = 1'b1; end
      if (i == 3 || i == 7) begin redirect_valid = 1'b1; redirect_pc = 32'h203; end
      if (i == 8) run = 1'b0;
      @(negedge clk);
      if (mem_re) begin
        total++;
        if (nreq >= 3 || i != ec[nreq] || mem_addr !== ea[nreq]) begin
          bad++;
          $display("FAIL rc_req got cycle=%0d addr=%h (req#%0d)", i, mem_addr, nreq);
        end
        nreq++;
      end
      if (i == 4 || i == 8) begin
        total++;
        if (inst_valid !== 1'b0 || fetch_count !== 32'd5) begin
          bad++;
          $display("FAIL rc_dropped cycle=%0d got v=%b cnt=%0d required v=0 cnt=5", i, inst_valid, fetch_count);
        end
      end
    end
    total++;
    if (nreq != 3) begin bad++; $display("FAIL rc_req_count got=%0d required=3", nreq); end
    total++;
    if (fetch_count !== 32'd6) begin bad++; $display("FAIL rc_fetch_count got=%0d required=6", fetch_count); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL rc_drain got pending=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_pc_wrap();
    int unsigned ec[2];
    logic [31:0] ea[2];
    int unsigned nreq = 0;
    ec = '{1, 4};
    ea = '{32'hFFFF_FFFC, 32'h0};
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 0) run2 = 1'b1;
      if (i == 4) run2 = 1'b0;
      @(negedge clk);
      if (mem_re2) begin
        total++;
        if (nreq >= 2 || i != ec[nreq] || mem_addr2 !== ea[nreq]) begin
          bad++;
          $display("FAIL wrap_req got cycle=%0d addr=%h (req#%0d)", i, mem_addr2, nreq);
        end
        nreq++;
      end
      if (i == 3) begin
        total++;
        if (inst_valid2 !== 1'b1 || inst2 !== 32'hABCD_0013 || inst_pc2 !== 32'hFFFF_FFFC) begin
          bad++;
          $display("FAIL wrap_inst got v=%b inst=%h pc=%h required v=1 inst=abcd0013 pc=fffffffc",
                   inst_valid2, inst2, inst_pc2);
        end
      end
    end
    total++;
    if (nreq != 2) begin bad++; $display("FAIL wrap_req_count got=%0d required=2", nreq); end
    total++;
    if (fetch_count2 !== 32'd2) begin bad++; $display("FAIL wrap_fetch_count got=%0d required=2", fetch_count2); end
  endtask

  task automatic test_run_stop_and_reset();
    mem[129] = 32'h3333_3333;
    exp_q.push_back('{32'h3333_3333, 32'h204});
    for (int i = 0; i < 11; i++) begin
      step();
      if (i == 0) begin run = 1'b1; delay = 3; inst_ready = 1'b1; end
      if (i == 2) run = 1'b0;
      @(negedge clk);
      if (i >= 6) begin
        total++;
        if (mem_re !== 1'b0 || inst_valid !== 1'b0) begin
          bad++;
          $display("FAIL park_idle cycle=%0d got re=%b v=%b required re=0 v=0", i, mem_re, inst_valid);
        end
      end
    end
    total++;
    if (fetch_count !== 32'd7) begin bad++; $display("FAIL park_fetch_count got=%0d required=7", fetch_count); end
    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL park_drain got pending=%0d required=0", exp_q.size()); end

    step();
    run = 1'b1;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (mem_re !== 1'b0 || mem_addr !== 32'h0 || inst_valid !== 1'b0 ||
        inst !== 32'h0 || inst_pc !== 32'h0 || fetch_count !== 32'h0) begin
      bad++;
      $display("FAIL async_reset got re=%b addr=%h v=%b inst=%h pc=%h cnt=%h required all zero",
               mem_re, mem_addr, inst_valid, inst, inst_pc, fetch_count);
    end
    step();
    run = 1'b0;
    rst = 1'b0;
    step();
    step();
    @(negedge clk);
    total++;
    if (mem_re !== 1'b0 || inst_valid !== 1'b0 || fetch_count !== 32'h0) begin
      bad++;
      $display("FAIL post_reset_idle got re=%b v=%b cnt=%0d required re=0 v=0 cnt=0",
               mem_re, inst_valid, fetch_count);
    end
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; run2 = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
    zero_mode = 1'b0; delay = 3;
    for (int unsigned k = 0; k < 256; k++) mem[k] = '0;
    mem[0] = 32'h0000_0013;
    mem[1] = 32'h0010_0093;
    mem[2] = 32'h0020_0113;
    mem[3] = 32'h0030_0193;

    test_reset();
    test_zero_delay();
    test_stall();
    test_redirect_wait();
    test_redirect_collide();
    test_pc_wrap();
    test_run_stop_and_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
